// File: rtl/noc_tg_pkg.sv
// rtl/noc_tg_pkg.sv - shared types and field offsets for the NoC traffic generator/checker pair
//
// Purpose: tdata field offsets, the decoded packet struct and the TG/TC run
// state enum. Struct field widths match the default NoC configuration
// (2-bit tid/tdest, 32-bit sequence, 512-bit tdata); users cast into and
// out of the struct with their own parameter widths.
// Ports: none (package).
package noc_tg_pkg;

  localparam int PKT_TDATA_W = 512;
  localparam int PKT_TID_W   = 2;
  localparam int PKT_TDEST_W = 2;
  localparam int PKT_SEQ_W   = 32;
  localparam int PKT_TICK_W  = PKT_TDATA_W / 2;

  // Sequence number sits at the bottom of tdata, the send tick in the upper half.
  localparam int SEQ_LSB  = 0;
  localparam int TICK_LSB = PKT_TDATA_W / 2;

  typedef struct packed {
    logic [PKT_TID_W-1:0]   tid;
    logic [PKT_TDEST_W-1:0] tdest;
    logic [PKT_SEQ_W-1:0]   seq;
    logic [PKT_TICK_W-1:0]  sent;
    logic                   last;
  } pkt_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } tg_state_t;

endpackage

// File: rtl/tc_seq_tracker.sv
// rtl/tc_seq_tracker.sv - per-source expected sequence number tracker
//
// Purpose: holds exp[s] for every tracked source and reports whether the
// packet currently in stage 2 carries the expected sequence number.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clear        start-of-run clear of all expected values
//   update       stage-2 packet is a valid in-range tlast beat; commit seq+1
//   tid, seq     source id and sequence number of the stage-2 packet
//   seq_ok       seq matches the expected value for tid
module tc_seq_tracker #(
  parameter int COUNT_WIDTH = 32,
  parameter int TID_WIDTH   = 2,
  parameter int NUM_ROUTERS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   update,
  input  logic [TID_WIDTH-1:0]   tid,
  input  logic [COUNT_WIDTH-1:0] seq,
  output logic                   seq_ok
);

  logic [COUNT_WIDTH-1:0] exp_seq [NUM_ROUTERS];

  // The write below lands on the same edge that moves the next packet into
  // stage 2, so this combinational read already sees the freshly updated
  // exp[s]: back-to-back packets from one source are compared against the
  // forwarded value without an extra bypass register.
  assign seq_ok = (seq == exp_seq[tid]);

  // In order or not, the next expected value is seq+1: an in-order packet
  // advances by one, an out-of-order one resynchronises to its own seq.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NUM_ROUTERS; i++) exp_seq[i] <= '0;
    end else if (update) begin
      exp_seq[tid] <= seq + 1'b1;
    end
  end

endmodule

// File: rtl/axis_tc_sim.sv
// rtl/axis_tc_sim.sv - NoC egress traffic checker / packet sink
//
// Purpose: consumes one-beat packets from an AXIS egress port, checks
// per-source sequence order and destination, measures latency from the
// embedded send tick and keeps run statistics. Optional latency histogram
// is enabled by defining AXIS_TC_LAT_HIST_EN.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, num_packets    start a run; run ends once total >= num_packets
//   ticks                 global tick count shared with the generators
//   done                  high while idle
//   recv_packets          per-source accepted packet count
//   total_recv_packets    all accepted beats
//   seq_errors            out-of-order or tlast=0 beats
//   dest_errors           tdest mismatch or untracked tid
//   lat_sum/min/max       latency statistics
//   axis_in_*             AXIS sink (always ready while running)
//   lat_hist              latency histogram (AXIS_TC_LAT_HIST_EN only)
module axis_tc_sim
  import noc_tg_pkg::*;
#(
  parameter int COUNT_WIDTH = 32,
  parameter int DEST        = 0,
  parameter int TDATA_WIDTH = 512,
  parameter int TDEST_WIDTH = 2,
  parameter int TID_WIDTH   = 2,
  parameter int NUM_ROUTERS = 4,
  parameter int LAT_WIDTH   = 32
`ifdef AXIS_TC_LAT_HIST_EN
  ,
  parameter int HIST_BINS   = 16,
  parameter int HIST_SHIFT  = 2
`endif
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [COUNT_WIDTH-1:0]                  num_packets,
  input  logic [TDATA_WIDTH/2-1:0]                ticks,
  output logic                                    done,
  output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] recv_packets,
  output logic [COUNT_WIDTH-1:0]                  total_recv_packets,
  output logic [COUNT_WIDTH-1:0]                  seq_errors,
  output logic [COUNT_WIDTH-1:0]                  dest_errors,
  output logic [2*LAT_WIDTH-1:0]                  lat_sum,
  output logic [LAT_WIDTH-1:0]                    lat_min,
  output logic [LAT_WIDTH-1:0]                    lat_max,
  input  logic                                    axis_in_tvalid,
  output logic                                    axis_in_tready,
  input  logic [TDATA_WIDTH-1:0]                  axis_in_tdata,
  input  logic                                    axis_in_tlast,
  input  logic [TID_WIDTH-1:0]                    axis_in_tid,
  input  logic [TDEST_WIDTH-1:0]                  axis_in_tdest
`ifdef AXIS_TC_LAT_HIST_EN
  ,
  output logic [COUNT_WIDTH-1:0]                  lat_hist [HIST_BINS]
`endif
);

  localparam int TICK_W = TDATA_WIDTH / 2;

  tg_state_t state, state_next;
  logic      accept;
  logic      stat_clear;

  // ---------------- run state machine ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUNNING;
      RUNNING: if (total_recv_packets >= num_packets) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done           = (state == IDLE);
    axis_in_tready = (state == RUNNING);
  end

  assign accept     = axis_in_tvalid && axis_in_tready;
  assign stat_clear = (state == IDLE) && start;

  // ---------------- stage 1: decode and latency ----------------
  pkt_t                   pkt_in;
  logic [LAT_WIDTH-1:0]   lat_in;
  logic                   unused_tdata;

  always_comb begin
    pkt_in       = '0;
    pkt_in.tid   = PKT_TID_W'(axis_in_tid);
    pkt_in.tdest = PKT_TDEST_W'(axis_in_tdest);
    pkt_in.seq   = PKT_SEQ_W'(axis_in_tdata[SEQ_LSB +: COUNT_WIDTH]);
    pkt_in.sent  = PKT_TICK_W'(axis_in_tdata[TDATA_WIDTH-1:TICK_W]);
    pkt_in.last  = axis_in_tlast;
  end

  // Modulo subtraction absorbs tick wrap between send and receive.
  assign lat_in       = LAT_WIDTH'(ticks - TICK_W'(pkt_in.sent));
  assign unused_tdata = ^axis_in_tdata[TICK_W-1:COUNT_WIDTH];

  logic                   s1_valid;
  logic [TID_WIDTH-1:0]   s1_tid;
  logic [TDEST_WIDTH-1:0] s1_tdest;
  logic [COUNT_WIDTH-1:0] s1_seq;
  logic                   s1_last;
  logic [LAT_WIDTH-1:0]   s1_lat;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
    end
    if (accept) begin
      s1_tid   <= TID_WIDTH'(pkt_in.tid);
      s1_tdest <= TDEST_WIDTH'(pkt_in.tdest);
      s1_seq   <= COUNT_WIDTH'(pkt_in.seq);
      s1_last  <= pkt_in.last;
      s1_lat   <= lat_in;
    end
  end

  // ---------------- stage 2: checks and statistics ----------------
  logic tid_ok;
  logic seq_ok;

  assign tid_ok = (int'(s1_tid) < NUM_ROUTERS);

  tc_seq_tracker #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .TID_WIDTH   (TID_WIDTH),
    .NUM_ROUTERS (NUM_ROUTERS)
  ) u_seq_tracker (
    .clk    (clk),
    .rst    (rst),
    .clear  (stat_clear),
    .update (s1_valid && s1_last && tid_ok),
    .tid    (s1_tid),
    .seq    (s1_seq),
    .seq_ok (seq_ok)
  );

  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      recv_packets       <= '0;
      total_recv_packets <= '0;
      seq_errors         <= '0;
      dest_errors        <= '0;
      lat_sum            <= '0;
      lat_min            <= '1;
      lat_max            <= '0;
    end else if (s1_valid) begin
      total_recv_packets <= total_recv_packets + 1'b1;
      lat_sum            <= lat_sum + {{LAT_WIDTH{1'b0}}, s1_lat};
      if (s1_lat < lat_min) lat_min <= s1_lat;
      if (s1_lat > lat_max) lat_max <= s1_lat;
      if (tid_ok) recv_packets[s1_tid] <= recv_packets[s1_tid] + 1'b1;
      // An untracked source is treated as misrouted; one count per beat.
      if (!tid_ok || (s1_tdest != TDEST_WIDTH'(DEST)))
        dest_errors <= dest_errors + 1'b1;
      // A tlast=0 beat is a framing error and never reaches the tracker.
      if (!s1_last || (tid_ok && !seq_ok))
        seq_errors <= seq_errors + 1'b1;
    end
  end

`ifdef AXIS_TC_LAT_HIST_EN
  logic [LAT_WIDTH-1:0] lat_shifted;
  int                   hist_bin;

  assign lat_shifted = s1_lat >> HIST_SHIFT;

  always_comb begin
    hist_bin = HIST_BINS - 1;
    if (lat_shifted < LAT_WIDTH'(HIST_BINS - 1)) hist_bin = int'(lat_shifted);
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      for (int i = 0; i < HIST_BINS; i++) lat_hist[i] <= '0;
    end else if (s1_valid) begin
      lat_hist[hist_bin] <= lat_hist[hist_bin] + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_tc_sim.sv
// tb/tb_axis_tc_sim.sv - self-checking bench for axis_tc_sim against a statistics model
module tb_axis_tc_sim;

  localparam int CW   = 32;
  localparam int TDW  = 512;
  localparam int TKW  = 256;
  localparam int LW   = 32;
  localparam int NR   = 4;
  localparam int DEST = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, start;
  logic [CW-1:0]          num_packets;
  logic [TKW-1:0]         ticks;
  logic                   done;
  logic [NR-1:0][CW-1:0]  recv_packets;
  logic [CW-1:0]          total_recv_packets, seq_errors, dest_errors;
  logic [2*LW-1:0]        lat_sum;
  logic [LW-1:0]          lat_min, lat_max;
  logic                   tvalid, tready, tlast;
  logic [TDW-1:0]         tdata;
  logic [1:0]             tid, tdest;
`ifdef AXIS_TC_LAT_HIST_EN
  logic [CW-1:0]          lat_hist [16];
`endif

  axis_tc_sim dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .num_packets        (num_packets),
    .ticks              (ticks),
    .done               (done),
    .recv_packets       (recv_packets),
    .total_recv_packets (total_recv_packets),
    .seq_errors         (seq_errors),
    .dest_errors        (dest_errors),
    .lat_sum            (lat_sum),
    .lat_min            (lat_min),
    .lat_max            (lat_max),
    .axis_in_tvalid     (tvalid),
    .axis_in_tready     (tready),
    .axis_in_tdata      (tdata),
    .axis_in_tlast      (tlast),
    .axis_in_tid        (tid),
    .axis_in_tdest      (tdest)
`ifdef AXIS_TC_LAT_HIST_EN
    ,
    .lat_hist           (lat_hist)
`endif
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference model: run statistics kept as plain counters.
  logic [CW-1:0]   m_exp  [NR];
  logic [CW-1:0]   m_recv [NR];
  logic [CW-1:0]   m_total, m_seqerr, m_desterr;
  logic [2*LW-1:0] m_latsum;
  logic [LW-1:0]   m_latmin, m_latmax;

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      m_exp[i]  = '0;
      m_recv[i] = '0;
    end
    m_total   = '0;
    m_seqerr  = '0;
    m_desterr = '0;
    m_latsum  = '0;
    m_latmin  = '1;
    m_latmax  = '0;
  endtask

  task automatic model_accept(input int s, input int d, input logic [CW-1:0] sq,
                              input logic lst, input logic [LW-1:0] lat);
    m_total++;
    m_latsum = m_latsum + 64'(lat);
    if (lat < m_latmin) m_latmin = lat;
    if (lat > m_latmax) m_latmax = lat;
    if (s >= NR) m_desterr++;
    else begin
      m_recv[s]++;
      if (d != DEST) m_desterr++;
    end
    if (!lst) m_seqerr++;
    else if (s < NR) begin
      if (sq != m_exp[s]) m_seqerr++;
      m_exp[s] = sq + 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".total"},   64'(total_recv_packets), 64'(m_total));
    check({tag, ".seqerr"},  64'(seq_errors),         64'(m_seqerr));
    check({tag, ".desterr"}, 64'(dest_errors),        64'(m_desterr));
    check({tag, ".latsum"},  lat_sum,                 m_latsum);
    check({tag, ".latmin"},  64'(lat_min),            64'(m_latmin));
    check({tag, ".latmax"},  64'(lat_max),            64'(m_latmax));
    for (int i = 0; i < NR; i++)
      check($sformatf("%s.recv%0d", tag, i), 64'(recv_packets[i]), 64'(m_recv[i]));
  endtask

  // One clock; inputs change 1 time unit after the edge, ticks advance each cycle.
  task automatic step();
    @(posedge clk);
    #1;
    ticks = ticks + 1;
  endtask

  task automatic start_run(input int n);
    num_packets = n;
    start = 1'b1;
    step();
    start = 1'b0;
    model_clear();
    check("run.entered", 64'(done), 64'd0);
  endtask

  task automatic send_beat(input int s, input int d, input logic [CW-1:0] sq,
                           input logic [TKW-1:0] sent, input logic lst);
    logic acc;
    tvalid = 1'b1;
    tid    = 2'(s);
    tdest  = 2'(d);
    tlast  = lst;
    tdata  = '0;
    tdata[CW-1:0]    = sq;
    tdata[TDW-1:TKW] = sent;
    acc = tready;
    if (acc) model_accept(s, d, sq, lst, LW'(ticks - sent));
    else check("beat.ready", 64'(acc), 64'd1);
    step();
    tvalid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60 && !done; i++) step();
    check({tag, ".done"}, 64'(done), 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_packets = '0; ticks = 256'd1000;
    tvalid = 1'b0; tlast = 1'b0; tdata = '0; tid = '0; tdest = '0;
    model_clear();
    step(); step(); step();
    rst = 1'b0;
    check_all("reset");
    check("reset.done", 64'(done), 64'd1);
    check("reset.ready", 64'(tready), 64'd0);

    // A: single source, in order, latency 5
    start_run(10);
    for (int k = 0; k < 10; k++) send_beat(1, DEST, CW'(k), ticks - 5, 1'b1);
    wait_done("A");
    check_all("A");
    check("A.recv1", 64'(recv_packets[1]), 64'd10);
    check("A.latmin5", 64'(lat_min), 64'd5);
    check("A.latmax5", 64'(lat_max), 64'd5);
    check("A.latsum50", lat_sum, 64'd50);

    // B: skipped sequence number resynchronises
    start_run(4);
    send_beat(2, DEST, 0, ticks - 7, 1'b1);
    send_beat(2, DEST, 1, ticks - 7, 1'b1);
    send_beat(2, DEST, 3, ticks - 7, 1'b1);
    send_beat(2, DEST, 4, ticks - 7, 1'b1);
    wait_done("B");
    check_all("B");
    check("B.seqerr1", 64'(seq_errors), 64'd1);

    // C: misrouted packet
    start_run(1);
    send_beat(0, DEST + 1, 0, ticks - 3, 1'b1);
    wait_done("C");
    check_all("C");
    check("C.desterr1", 64'(dest_errors), 64'd1);

    // D: interleaved sources every cycle, 2-cycle visibility
    start_run(4);
    send_beat(0, DEST, 0, ticks - 2, 1'b1);
    send_beat(1, DEST, 0, ticks - 4, 1'b1);
    send_beat(0, DEST, 1, ticks - 6, 1'b1);
    send_beat(1, DEST, 1, ticks - 8, 1'b1);
    check("D.pipe", 64'(total_recv_packets), 64'd3);
    wait_done("D");
    check_all("D");

    // E: tick wrap, sent = 2^256-3 at ticks = 2
    start_run(1);
    ticks = 256'd2;
    send_beat(3, DEST, 0, {TKW{1'b1}} - 2, 1'b1);
    wait_done("E");
    check_all("E");
    check("E.lat5", 64'(lat_min), 64'd5);

    // F: tlast=0 beat counts as an error and does not advance the sequence
    start_run(2);
    send_beat(3, DEST, 0, ticks - 1, 1'b0);
    send_beat(3, DEST, 0, ticks - 1, 1'b1);
    wait_done("F");
    check_all("F");
    check("F.seqerr1", 64'(seq_errors), 64'd1);

    // R: randomized traffic with gaps, occasional misorder/misroute/no-last
    start_run(40);
    for (int k = 0; k < 40; k++) begin
      int s, d, gap;
      logic [CW-1:0] sq;
      logic lst;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      s   = $urandom_range(0, NR - 1);
      d   = ($urandom_range(0, 7) == 0) ? 1 : DEST;
      sq  = ($urandom_range(0, 9) == 0) ? CW'($urandom) : m_exp[s];
      lst = ($urandom_range(0, 9) != 0);
      send_beat(s, d, sq, ticks - TKW'($urandom_range(0, 2000)), lst);
    end
    wait_done("R");
    check_all("R");

    // Reset mid-run with packets in flight
    start_run(100);
    send_beat(0, DEST, 0, ticks - 9, 1'b1);
    send_beat(1, DEST, 0, ticks - 9, 1'b1);
    send_beat(2, DEST, 0, ticks - 9, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    check_all("mrst");
    check("mrst.done", 64'(done), 64'd1);
    step();
    check_all("mrst2");

    // num_packets = 0: exactly one RUNNING cycle
    start_run(0);
    step();
    check("zero.done", 64'(done), 64'd1);
    check_all("zero");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
